edabk_uart_tx: RTL and testbench

EDABK_UART_TX -- requirements
Module: edabk_uart_tx

---
 rtl/edabk_uart_pkg.sv | 20 ++
 rtl/uart_tx_fifo.sv | 73 +++++++
 rtl/edabk_uart_tx.sv | 160 ++++++++++++++++
 tb/tb_edabk_uart_tx.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edabk_uart_pkg.sv
// Shared types and constants for the edabk UART transmitter.
// Optional parity support is enabled by defining UART_PARITY_EN.
package edabk_uart_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 8;

   // Indexed by the 3-bit baudrate select input.
   localparam int unsigned BAUD_TABLE [8] = '{1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through FIFO feeding the UART transmitter; the head word
// is presented combinationally, empty/full are registered from the occupancy.
module uart_tx_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  write,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  empty,
   output logic                  full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr_reg;
   logic [AW-1:0]         rd_ptr_reg;
   logic [AW:0]           count_reg;
   logic [AW:0]           count_next;
   logic                  empty_reg;
   logic                  full_reg;
   logic                  do_write;
   logic                  do_pop;

   // A full FIFO refuses writes even when a pop frees a slot this cycle.
   assign do_write = write && !full_reg;
   assign do_pop   = pop && !empty_reg;

   always_comb begin
      count_next = count_reg;
      case ({do_write, do_pop})
         2'b10:   count_next = count_reg + (AW+1)'(1);
         2'b01:   count_next = count_reg - (AW+1)'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         empty_reg  <= 1'b1;
         full_reg   <= 1'b0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         empty_reg  <= 1'b1;
         full_reg   <= 1'b0;
      end else begin
         if (do_write) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)   rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_next;
         empty_reg <= (count_next == '0);
         full_reg  <= (count_next == (AW+1)'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (do_write && !flush) mem[wr_ptr_reg] <= write_data;
   end

   assign head  = mem[rd_ptr_reg];
   assign empty = empty_reg;
   assign full  = full_reg;

endmodule

// File: rtl/edabk_uart_tx.sv
// UART transmitter: baud tick generator, FIFO and frame FSM.
// Define UART_PARITY_EN to honour the parity input (even parity bit per frame).
module edabk_uart_tx
   import edabk_uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            baudrate,
   input  logic                  start,
   input  logic                  parity,
   input  logic                  write,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic                  tx_out,
   output logic                  finish,
   output logic                  busy,
   output logic                  empty,
   output logic                  full,
   output logic                  bclk
);

   localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [31:0]           div_table [8];
   logic [31:0]           div_m1;
   logic [31:0]           baud_cnt_reg;
   logic [2:0]            baud_sel_reg;
   tx_state_t             state_reg, state_next;
   logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
   logic [DATA_WIDTH-1:0] data_reg, data_next;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic                  fifo_pop;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_div
         assign div_table[gi] = 32'(CLK_FREQ_HZ / BAUD_TABLE[gi]);
      end
   endgenerate

   assign div_m1 = div_table[baudrate] - 32'd1;
   // The tick is suppressed on the cycle a new rate is seen; the counter restarts next.
   assign bclk   = (baud_cnt_reg == div_m1) && (baudrate == baud_sel_reg);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         baud_cnt_reg <= '0;
         baud_sel_reg <= '0;
      end else begin
         baud_sel_reg <= baudrate;
         if (baudrate != baud_sel_reg || bclk) baud_cnt_reg <= '0;
         else                                  baud_cnt_reg <= baud_cnt_reg + 32'd1;
      end
   end

   uart_tx_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .write      (write),
      .pop        (fifo_pop),
      .flush      (flush),
      .write_data (write_data),
      .head       (fifo_head),
      .empty      (empty),
      .full       (full)
   );

`ifdef UART_PARITY_EN
   logic par_en_reg, par_en_next;
`else
   logic unused_parity;
   assign unused_parity = parity;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= ST_IDLE;
         bit_cnt_reg <= '0;
         data_reg    <= '0;
`ifdef UART_PARITY_EN
         par_en_reg  <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         bit_cnt_reg <= bit_cnt_next;
         data_reg    <= data_next;
`ifdef UART_PARITY_EN
         par_en_reg  <= par_en_next;
`endif
      end
   end

   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      data_next    = data_reg;
`ifdef UART_PARITY_EN
      par_en_next  = par_en_reg;
`endif
      fifo_pop     = 1'b0;
      finish       = 1'b0;
      tx_out       = 1'b1;
      busy         = (state_reg != ST_IDLE);
      case (state_reg)
         ST_IDLE: begin
            if (bclk && start && !empty) begin
               data_next  = fifo_head;
               fifo_pop   = 1'b1;
               state_next = ST_START;
`ifdef UART_PARITY_EN
               par_en_next = parity;
`endif
            end
         end
         ST_START: begin
            tx_out = 1'b0;
            if (bclk) begin
               state_next   = ST_DATA;
               bit_cnt_next = '0;
            end
         end
         ST_DATA: begin
            tx_out = data_reg[bit_cnt_reg];
            if (bclk) begin
               if (bit_cnt_reg == BIT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_PARITY_EN
                  state_next = par_en_reg ? ST_PARITY : ST_STOP;
`else
                  state_next = ST_STOP;
`endif
               end else begin
                  bit_cnt_next = bit_cnt_reg + BIT_W'(1);
               end
            end
         end
`ifdef UART_PARITY_EN
         ST_PARITY: begin
            tx_out = ^data_reg;
            if (bclk) state_next = ST_STOP;
         end
`endif
         ST_STOP: begin
            tx_out = 1'b1;
            if (bclk) begin
               finish     = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_edabk_uart_tx.sv
// Scoreboard bench for edabk_uart_tx at CLK_FREQ_HZ=1_152_000 (10 clk per bit at 115200).
// Expected frame layout follows UART_PARITY_EN when it is defined for the build.
module tb_edabk_uart_tx;

   typedef struct {
      logic [7:0] data;
      bit         par;
   } item_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [2:0] baudrate = 3'd7;
   logic       start = 1'b0;
   logic       parity = 1'b0;
   logic       write = 1'b0;
   logic       flush = 1'b0;
   logic [7:0] write_data = 8'h00;
   logic       tx_out, finish, busy, empty, full, bclk;

   item_t exp_q[$];
   int    checks = 0;
   int    failures = 0;
   int    finish_cnt = 0;

   edabk_uart_tx #(
      .DATA_WIDTH  (8),
      .FIFO_DEPTH  (16),
      .CLK_FREQ_HZ (1_152_000)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .baudrate   (baudrate),
      .start      (start),
      .parity     (parity),
      .write      (write),
      .flush      (flush),
      .write_data (write_data),
      .tx_out     (tx_out),
      .finish     (finish),
      .busy       (busy),
      .empty      (empty),
      .full       (full),
      .bclk       (bclk)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (finish === 1'b1) finish_cnt++;

   task automatic write_word(input logic [7:0] d, input bit push);
      item_t it;
      @(negedge clk);
      write = 1'b1;
      write_data = d;
      @(negedge clk);
      write = 1'b0;
      if (push) begin
         it.data = d;
`ifdef UART_PARITY_EN
         it.par = parity;
`else
         it.par = 1'b0;
`endif
         exp_q.push_back(it);
      end
   endtask

   // Pops one expected frame and checks every bit at its baud tick.
   task automatic rx_frame(input bit do_flush, input int start_bound);
      item_t      it;
      logic [11:0] bits;
      int         n;
      int         waited;
      checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL scoreboard: frame requested, expected queue size %0d required >0", exp_q.size());
         failures++;
         return;
      end
      it = exp_q.pop_front();
      bits = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = it.data[i];
      n = 9;
      if (it.par) begin
         bits[9] = ^it.data;
         n = 10;
      end
      bits[n] = 1'b1;
      n++;
      waited = 0;
      @(negedge clk);
      while (!(busy === 1'b1 && tx_out === 1'b0) && waited < start_bound) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (waited >= start_bound) begin
         $display("FAIL frame_start: data=0x%02h busy=%b tx_out=%b, required busy=1 tx_out=0 within %0d clk",
                  it.data, busy, tx_out, start_bound);
         failures++;
         return;
      end
      if (do_flush) begin
         flush = 1'b1;
         @(negedge clk);
         flush = 1'b0;
      end
      for (int b = 0; b < n; b++) begin
         waited = 0;
         @(negedge clk);
         while (bclk !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
         end
         checks++;
         if (waited >= 40) begin
            $display("FAIL bit_tick: data=0x%02h bit %0d no bclk in 40 clk, required a tick", it.data, b);
            failures++;
            return;
         end else if (tx_out !== bits[b]) begin
            $display("FAIL frame_bit%0d: data=0x%02h tx_out=%b, required %b", b, it.data, tx_out, bits[b]);
            failures++;
         end
      end
      $display("frame data=0x%02h parity_bit=%0d bits=%0d", it.data, it.par, n);
   endtask

   task automatic measure_period(input int expected);
      int waited;
      int n;
      waited = 0;
      @(negedge clk);
      while (bclk !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (waited >= 100) begin
         $display("FAIL bclk_present: baudrate=%0d no tick in 100 clk, required a tick", baudrate);
         failures++;
         return;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bclk !== 1'b1 && n < 100);
      checks++;
      if (n != expected) begin
         $display("FAIL bclk_period: baudrate=%0d period %0d clk, required %0d", baudrate, n, expected);
         failures++;
      end
      $display("baud sel=%0d period=%0d clk", baudrate, n);
   endtask

   task automatic test_reset();
      int bclk_hi;
      bclk_hi = 0;
      reset_n = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bclk === 1'b1) bclk_hi++;
      end
      checks += 6;
      if (bclk_hi != 0) begin $display("FAIL reset_bclk: %0d pulses, required 0", bclk_hi); failures++; end
      if (tx_out !== 1'b1) begin $display("FAIL reset_tx_out: %b, required 1", tx_out); failures++; end
      if (empty !== 1'b1) begin $display("FAIL reset_empty: %b, required 1", empty); failures++; end
      if (full !== 1'b0) begin $display("FAIL reset_full: %b, required 0", full); failures++; end
      if (finish !== 1'b0) begin $display("FAIL reset_finish: %b, required 0", finish); failures++; end
      if (busy !== 1'b0) begin $display("FAIL reset_busy: %b, required 0", busy); failures++; end
      $display("reset held 20 clk, bclk pulses=%0d", bclk_hi);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_baud();
      measure_period(10);
      @(negedge clk);
      baudrate = 3'd6;
      measure_period(20);
      @(negedge clk);
      baudrate = 3'd7;
      measure_period(10);
   endtask

   task automatic test_parity_frame();
      int f0;
      f0 = finish_cnt;
      parity = 1'b1;
      write_word(8'hAA, 1'b1);
      start = 1'b1;
      rx_frame(1'b0, 60);
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (finish_cnt - f0 != 1) begin
         $display("FAIL parity_finish: %0d pulses, required 1", finish_cnt - f0);
         failures++;
      end
   endtask

   task automatic test_plain_frame();
      int f0;
      f0 = finish_cnt;
      parity = 1'b0;
      write_word(8'hAB, 1'b1);
      start = 1'b1;
      rx_frame(1'b0, 60);
      start = 1'b0;
      @(negedge clk);
      checks += 2;
      if (busy !== 1'b0) begin $display("FAIL plain_len: busy=%b after stop, required 0", busy); failures++; end
      if (finish_cnt - f0 != 1) begin
         $display("FAIL plain_finish: %0d pulses, required 1", finish_cnt - f0);
         failures++;
      end
   endtask

   task automatic test_back_to_back();
      int f0;
      int busy_cycles;
      f0 = finish_cnt;
      parity = 1'b0;
      for (int i = 0; i < 16; i++) write_word(8'($urandom_range(0, 255)), 1'b1);
      checks++;
      if (full !== 1'b1) begin $display("FAIL full_flag: %b after 16 writes, required 1", full); failures++; end
      write_word(8'h5A, 1'b0);
      checks++;
      if (full !== 1'b1) begin $display("FAIL full_hold: %b after extra write, required 1", full); failures++; end
      start = 1'b1;
      rx_frame(1'b0, 60);
      for (int i = 1; i < 16; i++) rx_frame(1'b0, 12);
      busy_cycles = 0;
      repeat (300) begin
         @(negedge clk);
         if (busy === 1'b1) busy_cycles++;
      end
      start = 1'b0;
      checks += 3;
      if (busy_cycles != 0) begin $display("FAIL extra_dropped: busy %0d clk after 16 frames, required 0", busy_cycles); failures++; end
      if (empty !== 1'b1) begin $display("FAIL drain_empty: %b, required 1", empty); failures++; end
      if (finish_cnt - f0 != 16) begin
         $display("FAIL b2b_finish: %0d pulses, required 16", finish_cnt - f0);
         failures++;
      end
   endtask

   task automatic test_flush();
      int f0;
      int busy_cycles;
      f0 = finish_cnt;
      parity = 1'b0;
      for (int i = 0; i < 5; i++) write_word(8'(8'h31 + i * 8'h11), 1'b1);
      start = 1'b1;
      rx_frame(1'b0, 60);
      rx_frame(1'b1, 12);
      exp_q.delete();
      busy_cycles = 0;
      repeat (300) begin
         @(negedge clk);
         if (busy === 1'b1) busy_cycles++;
      end
      start = 1'b0;
      checks += 3;
      if (busy_cycles != 0) begin $display("FAIL flush_stop: busy %0d clk after flush, required 0", busy_cycles); failures++; end
      if (empty !== 1'b1) begin $display("FAIL flush_empty: %b, required 1", empty); failures++; end
      if (finish_cnt - f0 != 2) begin
         $display("FAIL flush_finish: %0d pulses, required 2", finish_cnt - f0);
         failures++;
      end
   endtask

   task automatic test_async_reset();
      int waited;
      int ticks;
      write_word(8'h00, 1'b0);
      write_word(8'h00, 1'b0);
      start = 1'b1;
      waited = 0;
      while (busy !== 1'b1 && waited < 60) begin
         @(negedge clk);
         waited++;
      end
      ticks = 0;
      while (ticks < 3 && waited < 200) begin
         @(negedge clk);
         waited++;
         if (bclk === 1'b1) ticks++;
      end
      checks += 2;
      if (tx_out !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL midframe_pre: tx_out=%b busy=%b, required tx_out=0 busy=1", tx_out, busy);
         failures++;
      end
      if (empty !== 1'b0) begin $display("FAIL midframe_fifo: empty=%b, required 0", empty); failures++; end
      #2 reset_n = 1'b0;
      #1;
      checks += 5;
      if (tx_out !== 1'b1) begin $display("FAIL async_tx_out: %b, required 1", tx_out); failures++; end
      if (busy !== 1'b0) begin $display("FAIL async_busy: %b, required 0", busy); failures++; end
      if (empty !== 1'b1) begin $display("FAIL async_empty: %b, required 1", empty); failures++; end
      if (full !== 1'b0 || finish !== 1'b0) begin
         $display("FAIL async_flags: full=%b finish=%b, required 0 0", full, finish);
         failures++;
      end
      if (bclk !== 1'b0) begin $display("FAIL async_bclk: %b, required 0", bclk); failures++; end
      $display("async reset mid-frame: tx_out=%b busy=%b empty=%b", tx_out, busy, empty);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_baud();
      test_parity_frame();
      test_plain_frame();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
